// File: rtl/uart_sld_loader.sv
// uart_sld_loader: core-side end of the host scene-data download link.
// It sends SYNC_BYTE over uart_tx, then receives LEN_BYTES bytes from uart_rx.
// The bytes are packed little-endian into 32-bit words and written to a memory port.
// Optional feature macro: SLD_LOADER_CHECKSUM_EN. When it is defined, an 8-bit sum
// of the payload is sent back over uart_tx before done rises.
module uart_sld_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int         LEN_BYTES = 910,
  parameter int         ADDR_W    = 10,
  parameter int         BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_ferr,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       byte_count
);

  localparam logic [15:0]       LAST_COUNT = 16'(LEN_BYTES);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

`ifdef SLD_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE, SYNC, SYNC_WAIT_HI, SYNC_WAIT_LO, RECV, FLUSH,
    CSUM, CSUM_WAIT_HI, CSUM_WAIT_LO, DONE, ERR
  } state_t;
  localparam state_t AFTER_WRITE = CSUM;
`else
  typedef enum logic [2:0] {
    IDLE, SYNC, SYNC_WAIT_HI, SYNC_WAIT_LO, RECV, FLUSH, DONE, ERR
  } state_t;
  localparam state_t AFTER_WRITE = DONE;
`endif

  state_t            state, state_next;
  logic [31:0]       asm_word, asm_next, filled;
  logic [ADDR_W-1:0] word_idx, idx_next, addr_next;
  logic [15:0]       count_next, count_inc;
  logic [31:0]       wdata_next;
  logic              we_next, txs_next;
  logic [7:0]        txd_next;
`ifdef SLD_LOADER_CHECKSUM_EN
  logic [7:0]        csum, csum_next;
`endif

  assign busy = !(state == IDLE || state == DONE || state == ERR);
  assign done = (state == DONE);
  assign err  = (state == ERR);

  // Next-state and next-register logic; every strobe defaults low so it lasts one cycle.
  always_comb begin
    state_next = state;
    count_next = byte_count;
    count_inc  = byte_count + 16'd1;
    asm_next   = asm_word;
    idx_next   = word_idx;
    we_next    = 1'b0;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    txs_next   = 1'b0;
    txd_next   = tx_data;
`ifdef SLD_LOADER_CHECKSUM_EN
    csum_next  = csum;
`endif
    filled = asm_word;
    case (byte_count[1:0])
      2'd0:    filled[7:0]   = rx_data;
      2'd1:    filled[15:8]  = rx_data;
      2'd2:    filled[23:16] = rx_data;
      default: filled[31:24] = rx_data;
    endcase

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          count_next = '0;
          asm_next   = '0;
          idx_next   = '0;
`ifdef SLD_LOADER_CHECKSUM_EN
          csum_next  = '0;
`endif
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (!tx_busy) begin
          txs_next   = 1'b1;
          txd_next   = SYNC_BYTE;
          state_next = SYNC_WAIT_HI;
        end
      end
      SYNC_WAIT_HI: if (tx_busy) state_next = SYNC_WAIT_LO;
      SYNC_WAIT_LO: if (!tx_busy) state_next = RECV;
      RECV: begin
        if (rx_ready) begin
          if (rx_ferr) begin
            state_next = ERR;
          end else begin
            count_next = count_inc;
`ifdef SLD_LOADER_CHECKSUM_EN
            csum_next  = csum + rx_data;
`endif
            if (byte_count[1:0] == 2'd3 || count_inc == LAST_COUNT) begin
              we_next    = 1'b1;
              wdata_next = filled;
              addr_next  = BASE + word_idx;
              idx_next   = word_idx + 1'b1;
              asm_next   = '0;
              if (count_inc == LAST_COUNT)
                state_next = (byte_count[1:0] == 2'd3) ? AFTER_WRITE : FLUSH;
            end else begin
              asm_next = filled;
            end
          end
        end
      end
      FLUSH: state_next = AFTER_WRITE;
`ifdef SLD_LOADER_CHECKSUM_EN
      CSUM: begin
        if (!tx_busy) begin
          txs_next   = 1'b1;
          txd_next   = csum;
          state_next = CSUM_WAIT_HI;
        end
      end
      CSUM_WAIT_HI: if (tx_busy) state_next = CSUM_WAIT_LO;
      CSUM_WAIT_LO: if (!tx_busy) state_next = DONE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset drops any partially assembled word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      byte_count <= '0;
      asm_word   <= '0;
      word_idx   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
`ifdef SLD_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_next;
      byte_count <= count_next;
      asm_word   <= asm_next;
      word_idx   <= idx_next;
      mem_we     <= we_next;
      mem_addr   <= addr_next;
      mem_wdata  <= wdata_next;
      tx_start   <= txs_next;
      tx_data    <= txd_next;
`ifdef SLD_LOADER_CHECKSUM_EN
      csum       <= csum_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_sld_loader.sv
// Testbench for uart_sld_loader.
// Two loaders share the UART link: one expects 910 bytes, the other expects 8 bytes.
// Each run is compared against a byte-stream reference model through scoreboard queues.
`timescale 1ns/1ps
module tb_uart_sld_loader;

  localparam logic [7:0] SYNC      = 8'hAA;
  localparam int         AW        = 10;
  localparam int         BASE_ADDR = 0;
  localparam int         LEN0      = 910;
  localparam int         LEN1      = 8;

  logic       clk      = 1'b0;
  logic       rstn     = 1'b0;
  logic [1:0] start    = '0;
  logic [7:0] rx_data  = '0;
  logic       rx_ready = 1'b0;
  logic       rx_ferr  = 1'b0;
  logic       tx_busy  = 1'b0;

  wire [7:0]    tx_data   [2];
  wire [1:0]    tx_start;
  wire [1:0]    mem_we;
  wire [AW-1:0] mem_addr  [2];
  wire [31:0]   mem_wdata [2];
  wire [1:0]    busy, done, err;
  wire [15:0]   byte_count [2];

  int n_compared   = 0;
  int n_mismatched = 0;
  int tx_cnt       = 0;
  int busy_len     = 10;

  logic [63:0] exp_wr_q [$];
  logic [63:0] exp_tx_q [$];

  uart_sld_loader #(.SYNC_BYTE(SYNC), .LEN_BYTES(LEN0), .ADDR_W(AW), .BASE_ADDR(BASE_ADDR)) dut0 (
    .clk(clk), .rstn(rstn), .start(start[0]),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
    .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .byte_count(byte_count[0])
  );

  uart_sld_loader #(.SYNC_BYTE(SYNC), .LEN_BYTES(LEN1), .ADDR_W(AW), .BASE_ADDR(BASE_ADDR)) dut1 (
    .clk(clk), .rstn(rstn), .start(start[1]),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
    .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .byte_count(byte_count[1])
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [63:0] wr_entry(input int id, input int addr, input logic [31:0] data);
    return (64'(id) << 42) | (64'(addr) << 32) | 64'(data);
  endfunction

  function automatic logic [63:0] tx_entry(input int id, input logic [7:0] data);
    return (64'(id) << 8) | 64'(data);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // uart_tx model: raises busy one cycle after a strobe and holds it high for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start != 2'b00) begin
        tx_cnt++;
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every write or transmit strobe pops and checks the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [63:0] act;
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_we[i]) begin
          act = wr_entry(i, int'(mem_addr[i]), mem_wdata[i]);
          if (exp_wr_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_write: got %0h, expected no write", act);
          end else begin
            checkOutput("mem_write", act, exp_wr_q.pop_front());
          end
        end
        if (tx_start[i]) begin
          act = tx_entry(i, tx_data[i]);
          if (exp_tx_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_tx: got %0h, expected no strobe", act);
          end else begin
            checkOutput("tx_byte", act, exp_tx_q.pop_front());
          end
        end
      end
    end
  end

  // One download on loader id; ferr_at/reset_at of -1 disable the error and reset cases.
  task automatic applyStimulus(input int id, input int len, input bit counting,
                               input int ferr_at, input int reset_at, input int hold);
    logic [7:0]  bytes [$];
    logic [31:0] word;
    int          n;
    int          prev_tx;
`ifdef SLD_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
    sum = '0;
`endif
    for (int k = 0; k < len; k++)
      bytes.push_back(counting ? 8'(k + 1) : 8'($urandom_range(0, 255)));
    busy_len = hold;
    exp_tx_q.push_back(tx_entry(id, SYNC));
    prev_tx = tx_cnt;
    start[id] = 1'b1;
    step();
    start[id] = 1'b0;

    n = 0;
    while (tx_cnt == prev_tx && n < 100) begin step(); n++; end
    checkOutput("sync_strobe_seen", 64'(tx_cnt - prev_tx), 64'd1);
    n = 0;
    while (!tx_busy && n < 20) begin step(); n++; end
    checkOutput("tx_busy_rose", 64'(tx_busy), 64'd1);
    step();
    step();
    rx_data  = 8'($urandom);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    n = 0;
    while (tx_busy && n < 50) begin step(); n++; end
    checkOutput("tx_busy_fell", 64'(tx_busy), 64'd0);
    step();

    for (int k = 0; k < len; k++) begin
      if (k == reset_at) break;
      repeat ($urandom_range(0, 2)) begin
        rx_data = 8'($urandom);
        step();
      end
      rx_data  = bytes[k];
      rx_ready = 1'b1;
      rx_ferr  = (k == ferr_at);
      if (k == ferr_at) begin
        step();
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        break;
      end
      if (k == len / 2) start[id] = 1'b1;
`ifdef SLD_LOADER_CHECKSUM_EN
      sum = sum + bytes[k];
`endif
      if (k % 4 == 3 || k == len - 1) begin
        word = '0;
        for (int j = k - k % 4; j <= k; j++)
          word = word | (32'(bytes[j]) << (8 * (j % 4)));
        exp_wr_q.push_back(wr_entry(id, (BASE_ADDR + k / 4) % (1 << AW), word));
      end
      step();
      rx_ready  = 1'b0;
      start[id] = 1'b0;
    end

    if (reset_at >= 0) begin
      rstn = 1'b0;
      #1;
      checkOutput("reset_mid_flags",
                  64'({mem_we[id], tx_start[id], busy[id], done[id], err[id], byte_count[id], tx_data[id]}), 64'd0);
      checkOutput("reset_mid_mem_port", 64'({mem_addr[id], mem_wdata[id]}), 64'd0);
      step();
      step();
      rstn = 1'b1;
      repeat (4) step();
      checkOutput("no_write_after_reset", 64'(exp_wr_q.size()), 64'd0);
    end else if (ferr_at >= 0) begin
      repeat (4) step();
      checkOutput("err_flags", 64'({err[id], done[id], busy[id]}), 64'b100);
      checkOutput("err_byte_count", 64'(byte_count[id]), 64'(ferr_at));
      checkOutput("err_no_pending_write", 64'(exp_wr_q.size()), 64'd0);
    end else begin
`ifdef SLD_LOADER_CHECKSUM_EN
      exp_tx_q.push_back(tx_entry(id, sum));
`endif
      n = 0;
      while (!done[id] && n < 200) begin step(); n++; end
      checkOutput("done_flags", 64'({done[id], err[id], busy[id]}), 64'b100);
      checkOutput("done_byte_count", 64'(byte_count[id]), 64'(len));
      repeat (3) step();
      checkOutput("all_writes_seen", 64'(exp_wr_q.size()), 64'd0);
      checkOutput("all_tx_seen", 64'(exp_tx_q.size()), 64'd0);
    end
  endtask

  // Test sequence: reset state, nominal downloads, reset mid-stream, framing errors, random runs.
  initial begin
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_flags",
                  64'({mem_we[i], tx_start[i], busy[i], done[i], err[i], byte_count[i], tx_data[i]}), 64'd0);
      checkOutput("reset_mem_port", 64'({mem_addr[i], mem_wdata[i]}), 64'd0);
    end
    rstn = 1'b1;
    step();

    applyStimulus(1, LEN1, 1'b1, -1, -1, 10);
    applyStimulus(0, LEN0, 1'b0, -1, -1, $urandom_range(4, 12));
    applyStimulus(0, LEN0, 1'b0, -1, 5, 6);
    applyStimulus(0, LEN0, 1'b0, -1, -1, 10);
    applyStimulus(1, LEN1, 1'b0, 2, -1, 5);
    applyStimulus(1, LEN1, 1'b0, -1, -1, 4);
    applyStimulus(0, LEN0, 1'b0, 500, -1, 7);
    for (int r = 0; r < 4; r++)
      applyStimulus(1, LEN1, 1'b0, -1, -1, $urandom_range(4, 12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
